// File: rtl/acc_cpu_core.sv
// Accumulator processor core: FETCH/EXEC sequencer, 4-bit opcode ISA, register file,
// writable program memory and a multi-cycle restoring divider.
module acc_cpu_core #(
  parameter int DW  = 8,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           pause,
  input  logic           start,
  input  logic           prog_we,
  input  logic [OPW-1:0] prog_addr,
  input  logic [OPW+3:0] prog_data,
  input  logic [OPW-1:0] dbg_raddr,
  output logic [DW-1:0]  dbg_rdata,
  output logic [DW-1:0]  acc,
  output logic [DW-1:0]  ext,
  output logic           cb,
  output logic           halted,
  output logic           busy
);

  localparam int IW    = OPW + 4;
  localparam int DEPTH = 2 ** OPW;
  localparam int CW    = $clog2(DW + 1);

  localparam logic [3:0] OP_SYS = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4, OP_AND = 4'h5, OP_XOR = 4'h6, OP_CMP = 4'h7;
  localparam logic [3:0] OP_BR  = 4'h8, OP_LDA = 4'h9, OP_STA = 4'hA, OP_JMP = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {S_HALT, S_FETCH, S_EXEC, S_DIV} state_t;

  state_t         state, state_nx;
  logic [OPW-1:0] pc, pc_nx;
  logic [IW-1:0]  ir;
  logic [DW-1:0]  acc_nx, ext_nx;
  logic           cb_nx;
  logic           reg_we, div_go, do_halt;

  logic [IW-1:0]  prog_mem [DEPTH];
  logic [DW-1:0]  regs     [DEPTH];

  logic [DW-1:0]  div_q, div_r;
  logic [CW-1:0]  div_cnt;

  logic [3:0]      opcode;
  logic [OPW-1:0]  n;
  logic [DW-1:0]   rn;
  logic [DW:0]     sum, diff, inc, dec;
  logic [2*DW-1:0] prod;

  assign opcode = ir[IW-1:OPW];
  assign n      = ir[OPW-1:0];
  assign rn     = regs[n];

  // The top bit of each DW+1 wide result is the carry (add) or borrow (subtract).
  assign sum  = {1'b0, acc} + {1'b0, rn};
  assign diff = {1'b0, acc} - {1'b0, rn};
  assign inc  = {1'b0, acc} + (DW+1)'(1);
  assign dec  = {1'b0, acc} - (DW+1)'(1);
  assign prod = {{DW{1'b0}}, acc} * {{DW{1'b0}}, rn};

  // One restoring step: shift the next dividend bit into the partial remainder, keep the trial
  // subtraction only if it did not borrow.
  logic [DW:0]   rem_sh, trial;
  logic          fits;
  logic [DW-1:0] step_q, step_r;

  assign rem_sh = {div_r, div_q[DW-1]};
  assign trial  = rem_sh - {1'b0, rn};
  assign fits   = ~trial[DW];
  assign step_r = fits ? trial[DW-1:0] : rem_sh[DW-1:0];
  assign step_q = {div_q[DW-2:0], fits};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    acc_nx  = acc;
    ext_nx  = ext;
    cb_nx   = cb;
    pc_nx   = pc;
    reg_we  = 1'b0;
    div_go  = 1'b0;
    do_halt = 1'b0;
    case (opcode)
      OP_SYS: begin
        case (int'(n))
          1: acc_nx = {acc[DW-2:0], 1'b0};
          2: acc_nx = {1'b0, acc[DW-1:1]};
          3: acc_nx = {acc[0], acc[DW-1:1]};
          4: acc_nx = {acc[DW-2:0], acc[DW-1]};
          5: acc_nx = {acc[DW-1], acc[DW-1:1]};
          6: {cb_nx, acc_nx} = inc;
          7: {cb_nx, acc_nx} = dec;
          default: ;
        endcase
      end
      OP_ADD: {cb_nx, acc_nx} = sum;
      OP_SUB: {cb_nx, acc_nx} = diff;
      OP_MUL: {ext_nx, acc_nx} = prod;
      OP_DIV: begin
        if (rn == '0) begin
          acc_nx = '1;
          ext_nx = acc;
          cb_nx  = 1'b1;
        end else begin
          div_go = 1'b1;
        end
      end
      OP_AND: acc_nx = acc & rn;
      OP_XOR: acc_nx = acc ^ rn;
      OP_CMP: cb_nx  = diff[DW];
      OP_BR:  if (cb) pc_nx = n;
      OP_LDA: acc_nx = rn;
      OP_STA: reg_we = 1'b1;
      OP_JMP: pc_nx  = n;
      OP_HLT: do_halt = &n;
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (!pause) begin
      case (state)
        S_HALT:  if (start) state_nx = S_FETCH;
        S_FETCH: state_nx = S_EXEC;
        S_EXEC:  state_nx = do_halt ? S_HALT : (div_go ? S_DIV : S_FETCH);
        S_DIV:   if (div_cnt == CW'(1)) state_nx = S_FETCH;
        default: state_nx = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_HALT;
    else       state <= state_nx;
  end

  // NOTE: sequential state is written with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc      <= '0;
      ir      <= '0;
      acc     <= '0;
      ext     <= '0;
      cb      <= 1'b0;
      div_q   <= '0;
      div_r   <= '0;
      div_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= DW'(i + 1);
    end else if (!pause) begin
      case (state)
        S_HALT: if (start) pc <= '0;
        S_FETCH: begin
          ir <= prog_mem[pc];
          pc <= pc + OPW'(1);
        end
        S_EXEC: begin
          acc <= acc_nx;
          ext <= ext_nx;
          cb  <= cb_nx;
          pc  <= pc_nx;
          if (reg_we) regs[n] <= acc;
          if (div_go) begin
            div_q   <= acc;
            div_r   <= '0;
            div_cnt <= CW'(DW);
          end
        end
        S_DIV: begin
          div_q   <= step_q;
          div_r   <= step_r;
          div_cnt <= div_cnt - CW'(1);
          if (div_cnt == CW'(1)) begin
            acc <= step_q;
            ext <= step_r;
            cb  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: program memory has no reset so it maps onto plain RAM; its contents survive rstn.
  always_ff @(posedge clk) begin
    if (prog_we && state == S_HALT) prog_mem[prog_addr] <= prog_data;
  end

  assign dbg_rdata = regs[dbg_raddr];
  assign halted    = (state == S_HALT);
  assign busy      = (state != S_HALT);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: directed program table, pause/reset sequences,
// and random straight-line programs compared against an instruction-level model.
module tb_acc_cpu_core;

  logic       clk = 1'b0, rstn = 1'b0, pause = 1'b0, start = 1'b0, prog_we = 1'b0;
  logic [3:0] prog_addr = '0, dbg_raddr = '0;
  logic [7:0] prog_data = '0;
  logic [7:0] dbg_rdata, acc, ext;
  logic       cb, halted, busy;

  int checks = 0, failures = 0;

  acc_cpu_core #(.DW(8), .OPW(4)) dut (
    .clk(clk), .rstn(rstn), .pause(pause), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata), .acc(acc), .ext(ext), .cb(cb), .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] prog [16];
    logic [7:0] e_acc, e_ext;
    logic       e_cb;
    int         e_cyc;
    logic [3:0] d_addr;
    logic [7:0] d_val;
  } vec_t;

  vec_t vecs [7];

  // Instruction-level reference model
  int         m_acc, m_ext, m_cb;
  int         m_r [16];
  logic [7:0] m_prog [16];
  logic [7:0] rp [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_acc = 0; m_ext = 0; m_cb = 0;
    for (int i = 0; i < 16; i++) m_r[i] = i + 1;
  endfunction

  function automatic int model_run();
    int pc = 0, cyc = 0;
    for (int step = 0; step < 64; step++) begin
      int ins, op, n, r, t;
      ins = int'(m_prog[pc]);
      op  = ins / 16;
      n   = ins % 16;
      r   = m_r[n];
      pc  = (pc + 1) % 16;
      cyc += 2;
      case (op)
        0: case (n)
             1: m_acc = (m_acc * 2) % 256;
             2: m_acc = m_acc / 2;
             3: m_acc = m_acc / 2 + (m_acc % 2) * 128;
             4: m_acc = (m_acc * 2) % 256 + m_acc / 128;
             5: m_acc = m_acc / 2 + (m_acc & 128);
             6: begin m_cb = (m_acc == 255); m_acc = (m_acc + 1) % 256; end
             7: begin m_cb = (m_acc == 0);   m_acc = (m_acc + 255) % 256; end
             default: ;
           endcase
        1: begin t = m_acc + r; m_cb = (t > 255); m_acc = t % 256; end
        2: begin m_cb = (m_acc < r); m_acc = (m_acc - r + 256) % 256; end
        3: begin t = m_acc * r; m_ext = t / 256; m_acc = t % 256; end
        4: if (r == 0) begin
             m_ext = m_acc; m_acc = 255; m_cb = 1;
           end else begin
             m_ext = m_acc % r; m_acc = m_acc / r; m_cb = 0; cyc += 8;
           end
        5: m_acc = m_acc & r;
        6: m_acc = m_acc ^ r;
        7: m_cb = (m_acc < r);
        8: if (m_cb != 0) pc = n;
        9: m_acc = r;
        10: m_r[n] = m_acc;
        11: pc = n;
        15: if (n == 15) return cyc;
        default: ;
      endcase
    end
    return -1;
  endfunction

  task automatic reset_dut();
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    model_reset();
  endtask

  task automatic load_prog(input logic [7:0] p [16]);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = p[i]; m_prog[i] = p[i];
    end
    @(negedge clk); prog_we = 1'b0;
  endtask

  // Returns the number of clock edges from the start edge until halted rises.
  task automatic run_prog(output int cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!halted && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 400) check("run_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic set_vec(input int k, input string nm, input logic [7:0] a, input logic [7:0] e,
                         input logic c, input int cy, input logic [3:0] da, input logic [7:0] dv);
    vecs[k].name = nm; vecs[k].e_acc = a; vecs[k].e_ext = e; vecs[k].e_cb = c;
    vecs[k].e_cyc = cy; vecs[k].d_addr = da; vecs[k].d_val = dv;
  endtask

  initial begin
    int cyc, mcyc;
    logic [7:0] s_acc, s_ext;
    logic       s_cb;

    vecs[0].prog = '{8'h91, 8'h61, 8'h15, 8'h16, 8'hA7, 8'hFF, 8'hFF, 8'hFF,
                     8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    set_vec(0, "basic",   8'h0D, 8'h00, 1'b0, 12, 4'd7,  8'd13);
    vecs[1].prog = '{8'h99, 8'h39, 8'h46, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                     8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    set_vec(1, "div",     8'h0E, 8'h02, 1'b0, 16, 4'd6,  8'd7);
    vecs[2].prog = '{8'hA3, 8'h99, 8'h43, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                     8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    set_vec(2, "div0",    8'hFF, 8'h0A, 1'b1, 8,  4'd3,  8'd0);
    vecs[3].prog = '{8'h99, 8'h39, 8'hA0, 8'h10, 8'h3F, 8'h92, 8'h24, 8'h89,
                     8'h06, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    set_vec(3, "mul_sub_br", 8'hFE, 8'h0C, 1'b1, 18, 4'd0, 8'd100);
    vecs[4].prog = '{8'h9F, 8'h01, 8'h04, 8'h03, 8'h02, 8'h05, 8'h07, 8'h66,
                     8'h07, 8'h06, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    set_vec(4, "shifts",  8'h00, 8'h00, 1'b1, 22, 4'd15, 8'd16);
    vecs[5].prog = '{8'h84, 8'h9C, 8'h7D, 8'hBE, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                     8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h5E, 8'h01};
    set_vec(5, "pc_wrap", 8'h1A, 8'h00, 1'b1, 16, 4'd13, 8'd14);
    vecs[6].prog = '{8'hBF, 8'hFF, 8'hFF, 8'h9A, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                     8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hB3};
    set_vec(6, "jmp_top", 8'h0B, 8'h00, 1'b0, 8,  4'd10, 8'd11);

    // Reset state
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_ext", 32'(ext), 32'd0);
    check("rst_cb", 32'(cb), 32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) begin
      dbg_raddr = 4'(i); #1;
      check($sformatf("rst_reg%0d", i), 32'(dbg_rdata), 32'(i + 1));
    end

    // Directed program table, each from reset state
    for (int k = 0; k < 7; k++) begin
      reset_dut();
      load_prog(vecs[k].prog);
      run_prog(cyc);
      check({vecs[k].name, "_acc"}, 32'(acc), 32'(vecs[k].e_acc));
      check({vecs[k].name, "_ext"}, 32'(ext), 32'(vecs[k].e_ext));
      check({vecs[k].name, "_cb"}, 32'(cb), 32'(vecs[k].e_cb));
      check({vecs[k].name, "_cycles"}, 32'(cyc), 32'(vecs[k].e_cyc));
      dbg_raddr = vecs[k].d_addr; #1;
      check({vecs[k].name, "_dbg"}, 32'(dbg_rdata), 32'(vecs[k].d_val));
    end

    // Pause for 3 cycles mid-DIV, with an ignored program write while busy
    reset_dut();
    load_prog(vecs[1].prog);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!halted && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 9) begin
        s_acc = acc; s_ext = ext; s_cb = cb;
        pause = 1'b1; prog_we = 1'b1; prog_addr = 4'd3; prog_data = 8'h06;
        for (int p = 0; p < 3; p++) begin
          @(negedge clk);
          cyc++;
          check("pause_acc", 32'(acc), 32'(s_acc));
          check("pause_ext", 32'(ext), 32'(s_ext));
          check("pause_cb", 32'(cb), 32'(s_cb));
          check("pause_busy", 32'(busy), 32'd1);
        end
        pause = 1'b0; prog_we = 1'b0;
      end
    end
    check("pause_div_acc", 32'(acc), 32'd14);
    check("pause_div_ext", 32'(ext), 32'd2);
    check("pause_div_cb", 32'(cb), 32'd0);
    check("pause_div_cycles", 32'(cyc), 32'd19);

    // start while paused is ignored
    @(negedge clk); pause = 1'b1; start = 1'b1;
    @(negedge clk); pause = 1'b0; start = 1'b0;
    check("pause_start_halted", 32'(halted), 32'd1);

    // Asynchronous reset mid-DIV, then rerun the retained program
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rstn = 1'b0;
    #1;
    dbg_raddr = 4'd5; #1;
    check("midrst_acc", 32'(acc), 32'd0);
    check("midrst_ext", 32'(ext), 32'd0);
    check("midrst_halted", 32'(halted), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_reg5", 32'(dbg_rdata), 32'd6);
    @(negedge clk); rstn = 1'b1;
    model_reset();
    run_prog(cyc);
    check("rerun_acc", 32'(acc), 32'd14);
    check("rerun_ext", 32'(ext), 32'd2);
    check("rerun_cycles", 32'(cyc), 32'd16);

    // Random straight-line programs with forward branches, state carried over between runs
    reset_dut();
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 15; i++) begin
        int op;
        logic [3:0] nn;
        op = $urandom_range(0, 13);
        nn = 4'($urandom_range(0, 15));
        if (op == 8 || op == 11) nn = 4'($urandom_range(i + 1, 15));
        if (op == 13) nn = 4'($urandom_range(0, 14));
        rp[i] = {(op == 13) ? 4'hF : 4'(op), nn};
      end
      rp[15] = 8'hFF;
      load_prog(rp);
      mcyc = model_run();
      run_prog(cyc);
      check($sformatf("rand%0d_acc", t), 32'(acc), 32'(m_acc));
      check($sformatf("rand%0d_ext", t), 32'(ext), 32'(m_ext));
      check($sformatf("rand%0d_cb", t), 32'(cb), 32'(m_cb));
      check($sformatf("rand%0d_cycles", t), 32'(cyc), 32'(mcyc));
      for (int i = 0; i < 16; i++) begin
        dbg_raddr = 4'(i); #1;
        check($sformatf("rand%0d_reg%0d", t, i), 32'(dbg_rdata), 32'(m_r[i]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
